// File: rtl/io_bus_pkg.sv
// Shared types and constants for the Z80 I/O bus cycle controller.
package io_bus_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    TW   = 3'd3,
    T3   = 3'd4
  } state_t;

  localparam int         AUTO_WAIT_DEFAULT = 1;
  localparam int         TIMEOUT_DEFAULT   = 0;
  localparam logic [7:0] TIMEOUT_FILL      = 8'hFF;

endpackage

// File: rtl/io_wait_counter.sv
// Mandatory-wait down-counter and consecutive WAIT_n-low sample counter.
module io_wait_counter #(
  parameter int CNT_W   = 3,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  input  logic             clear,
  input  logic             inc,
  output logic             wait_zero,
  output logic             to_last
);

  logic [CNT_W-1:0] wait_cnt;
  logic [TO_W-1:0]  to_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      if (load)
        wait_cnt <= load_value;
      else if (dec && wait_cnt != '0)
        wait_cnt <= wait_cnt - 1'b1;

      if (clear)
        to_cnt <= '0;
      else if (inc)
        to_cnt <= to_cnt + 1'b1;
    end
  end

  // to_last is high on the sample that would be the TIMEOUT-th consecutive low one.
  always_comb begin
    wait_zero = (wait_cnt == '0);
    to_last   = (TIMEOUT != 0) && (to_cnt == TO_W'(TIMEOUT - 1));
  end

endmodule

// File: rtl/io_bus_cycle_controller.sv
// Runs the external Z80 IN r,(C) / OUT (C),r bus cycle: T1, T2, TW..., T3.
module io_bus_cycle_controller
  import io_bus_pkg::*;
#(
  parameter int AUTO_WAIT = AUTO_WAIT_DEFAULT,
  parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PC_I0,
  input  logic        PC_O0,
  input  logic [15:0] Address,
  input  logic [7:0]  OutData,
  output logic [15:0] BusAddress,
  output logic [7:0]  BusDataOut,
  output logic        BusDataOE,
  input  logic [7:0]  BusDataIn,
  output logic        IORQ_n,
  output logic        RD_n,
  output logic        WR_n,
  input  logic        WAIT_n,
  output logic [7:0]  InData,
  output logic        InSign,
  output logic        InZero,
  output logic        InParity,
  output logic        Busy,
  output logic        Done,
  output logic        TimedOut,
  output logic        ProtoErr,
  output state_t      dbg_state
);

  // The counter holds the mandatory TW cycles still to pass before WAIT_n is sampled.
  localparam logic [2:0] WAIT_LOAD = (AUTO_WAIT > 0) ? 3'(AUTO_WAIT - 1) : 3'd0;

  state_t state;
  logic   is_read;
  logic   wait_zero, to_last;
  logic   start_any, in_sample, go_t3, timeout_hit;

  always_comb begin
    start_any   = PC_I0 | PC_O0;
    in_sample   = (state == T2 && AUTO_WAIT == 0) || (state == TW && wait_zero);
    timeout_hit = in_sample && !WAIT_n && to_last;
    go_t3       = in_sample && (WAIT_n || to_last);
    InSign      = InData[7];
    InZero      = (InData == 8'h00);
    InParity    = ~^InData;
    dbg_state   = state;
  end

  io_wait_counter #(
    .CNT_W  (3),
    .TO_W   (16),
    .TIMEOUT(TIMEOUT)
  ) u_wait_counter (
    .clk       (CLK),
    .reset     (RESET),
    .load      (state == T2),
    .load_value(WAIT_LOAD),
    .dec       (state == TW),
    .clear     (state == T1),
    .inc       (in_sample && !WAIT_n),
    .wait_zero (wait_zero),
    .to_last   (to_last)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      is_read    <= 1'b0;
      IORQ_n     <= 1'b1;
      RD_n       <= 1'b1;
      WR_n       <= 1'b1;
      BusAddress <= '0;
      BusDataOut <= '0;
      BusDataOE  <= 1'b0;
      InData     <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      TimedOut   <= 1'b0;
      ProtoErr   <= 1'b0;
    end else begin
      Done     <= 1'b0;
      ProtoErr <= 1'b0;
      case (state)
        IDLE: begin
          if (PC_I0 && PC_O0) begin
            ProtoErr <= 1'b1;
          end else if (start_any) begin
            state      <= T1;
            Busy       <= 1'b1;
            TimedOut   <= 1'b0;
            is_read    <= PC_I0;
            BusAddress <= Address;
            if (PC_O0) begin
              BusDataOut <= OutData;
              BusDataOE  <= 1'b1;
            end
          end
        end
        T1: begin
          state  <= T2;
          IORQ_n <= 1'b0;
          RD_n   <= ~is_read;
          WR_n   <= is_read;
        end
        T2, TW: begin
          if (go_t3) begin
            state  <= T3;
            IORQ_n <= 1'b1;
            RD_n   <= 1'b1;
            WR_n   <= 1'b1;
            Done   <= 1'b1;
            if (timeout_hit)
              TimedOut <= 1'b1;
            if (is_read)
              InData <= timeout_hit ? TIMEOUT_FILL : BusDataIn;
          end else begin
            state <= TW;
          end
        end
        T3: begin
          state     <= IDLE;
          Busy      <= 1'b0;
          BusDataOE <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      // A start while a cycle is running is rejected without disturbing it.
      if (state != IDLE && start_any)
        ProtoErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_bus_cycle_controller.sv
// Directed bench: default-parameter instance (a) and a TIMEOUT=4 instance (b).
module tb_io_bus_cycle_controller;
  import io_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  out_data;
  logic [7:0]  bus_data_in;

  logic        pc_i0_a, pc_o0_a, wait_a;
  logic [15:0] bus_addr_a;
  logic [7:0]  bus_dout_a, in_data_a;
  logic        oe_a, iorq_a, rd_a, wr_a, sign_a, zero_a, par_a;
  logic        busy_a, done_a, to_a, perr_a;
  state_t      st_a;

  logic        pc_i0_b, pc_o0_b, wait_b;
  logic [15:0] bus_addr_b;
  logic [7:0]  bus_dout_b, in_data_b;
  logic        oe_b, iorq_b, rd_b, wr_b, sign_b, zero_b, par_b;
  logic        busy_b, done_b, to_b, perr_b;
  state_t      st_b;

  int checks = 0;
  int errors = 0;
  int iorq_lo, rd_lo, wr_lo, oe_hi, done_at, done_cnt;
  logic [15:0] t1_addr;

  always #5 clk = ~clk;

  io_bus_cycle_controller dut_a (
    .CLK(clk), .RESET(reset), .PC_I0(pc_i0_a), .PC_O0(pc_o0_a),
    .Address(address), .OutData(out_data), .BusAddress(bus_addr_a),
    .BusDataOut(bus_dout_a), .BusDataOE(oe_a), .BusDataIn(bus_data_in),
    .IORQ_n(iorq_a), .RD_n(rd_a), .WR_n(wr_a), .WAIT_n(wait_a),
    .InData(in_data_a), .InSign(sign_a), .InZero(zero_a), .InParity(par_a),
    .Busy(busy_a), .Done(done_a), .TimedOut(to_a), .ProtoErr(perr_a),
    .dbg_state(st_a)
  );

  io_bus_cycle_controller #(.AUTO_WAIT(1), .TIMEOUT(4)) dut_b (
    .CLK(clk), .RESET(reset), .PC_I0(pc_i0_b), .PC_O0(pc_o0_b),
    .Address(address), .OutData(out_data), .BusAddress(bus_addr_b),
    .BusDataOut(bus_dout_b), .BusDataOE(oe_b), .BusDataIn(bus_data_in),
    .IORQ_n(iorq_b), .RD_n(rd_b), .WR_n(wr_b), .WAIT_n(wait_b),
    .InData(in_data_b), .InSign(sign_b), .InZero(zero_b), .InParity(par_b),
    .Busy(busy_b), .Done(done_b), .TimedOut(to_b), .ProtoErr(perr_b),
    .dbg_state(st_b)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after the start (T1).
  task automatic pulse_start(input bit sel, input logic i, input logic o);
    if (sel) begin pc_i0_b = i; pc_o0_b = o; end
    else     begin pc_i0_a = i; pc_o0_a = o; end
    tick();
    pc_i0_a = 1'b0; pc_o0_a = 1'b0;
    pc_i0_b = 1'b0; pc_o0_b = 1'b0;
  endtask

  // Walks a running cycle one negedge at a time, idx counting cycles after the start.
  task automatic observe(input bit sel, input int start_idx, input int release_at,
                         input int max_idx);
    logic io, rd, wr, oe, dn, bs;
    logic [15:0] ad;
    iorq_lo = 0; rd_lo = 0; wr_lo = 0; oe_hi = 0; done_at = 0; t1_addr = '0;
    for (int idx = start_idx; idx <= max_idx; idx++) begin
      if (sel) begin io = iorq_b; rd = rd_b; wr = wr_b; oe = oe_b; dn = done_b; bs = busy_b; ad = bus_addr_b; end
      else     begin io = iorq_a; rd = rd_a; wr = wr_a; oe = oe_a; dn = done_a; bs = busy_a; ad = bus_addr_a; end
      if (!io) iorq_lo++;
      if (!rd) rd_lo++;
      if (!wr) wr_lo++;
      if (oe)  oe_hi++;
      if (dn)  done_at = idx;
      if (idx == 1) t1_addr = ad;
      if (!bs) break;
      if (idx == release_at) begin
        if (sel) wait_b = 1'b1; else wait_a = 1'b1;
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    pc_i0_a = 1'b0; pc_o0_a = 1'b0; wait_a = 1'b1;
    pc_i0_b = 1'b0; pc_o0_b = 1'b0; wait_b = 1'b1;
    address = 16'h0000; out_data = 8'h00; bus_data_in = 8'h00;
    repeat (3) tick();

    check("rst_iorq", iorq_a, 1'b1);
    check("rst_rd", rd_a, 1'b1);
    check("rst_wr", wr_a, 1'b1);
    check("rst_addr", bus_addr_a, 16'h0000);
    check("rst_dout", bus_dout_a, 8'h00);
    check("rst_oe", oe_a, 1'b0);
    check("rst_indata", in_data_a, 8'h00);
    check("rst_inzero", zero_a, 1'b1);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_to", to_a, 1'b0);
    check("rst_perr", perr_a, 1'b0);
    check("rst_state", st_a, IDLE);
    reset = 1'b0;
    tick();

    // Nominal read.
    address = 16'h12FE; bus_data_in = 8'h81; wait_a = 1'b1;
    pulse_start(1'b0, 1'b1, 1'b0);
    observe(1'b0, 1, 0, 20);
    check("rd_iorq_lo", iorq_lo, 2);
    check("rd_rd_lo", rd_lo, 2);
    check("rd_wr_lo", wr_lo, 0);
    check("rd_done_at", done_at, 4);
    check("rd_t1_addr", t1_addr, 16'h12FE);
    check("rd_indata", in_data_a, 8'h81);
    check("rd_sign", sign_a, 1'b1);
    check("rd_zero", zero_a, 1'b0);
    check("rd_parity", par_a, 1'b1);
    check("rd_addr_hold", bus_addr_a, 16'h12FE);

    // Back-to-back write in the first IDLE cycle, three WAIT_n-low samples.
    address = 16'hA55A; out_data = 8'h5A; bus_data_in = 8'h33; wait_a = 1'b0;
    pulse_start(1'b0, 1'b0, 1'b1);
    observe(1'b0, 1, 6, 30);
    check("wr_t1_addr", t1_addr, 16'hA55A);
    check("wr_wr_lo", wr_lo, 5);
    check("wr_iorq_lo", iorq_lo, 5);
    check("wr_rd_lo", rd_lo, 0);
    check("wr_oe_hi", oe_hi, 7);
    check("wr_done_at", done_at, 7);
    check("wr_dout", bus_dout_a, 8'h5A);
    check("wr_oe_idle", oe_a, 1'b0);
    check("wr_indata", in_data_a, 8'h81);

    // Both starts together in IDLE.
    pc_i0_a = 1'b1; pc_o0_a = 1'b1;
    tick();
    pc_i0_a = 1'b0; pc_o0_a = 1'b0;
    check("both_perr", perr_a, 1'b1);
    check("both_busy", busy_a, 1'b0);
    check("both_iorq", iorq_a, 1'b1);
    tick();
    check("both_perr_once", perr_a, 1'b0);
    check("both_busy2", busy_a, 1'b0);

    // Start pulse injected while in TW.
    address = 16'h0044; bus_data_in = 8'h07; wait_a = 1'b0;
    pulse_start(1'b0, 1'b1, 1'b0);
    tick();
    tick();
    pc_o0_a = 1'b1;
    tick();
    pc_o0_a = 1'b0;
    check("tw_perr", perr_a, 1'b1);
    check("tw_busy", busy_a, 1'b1);
    check("tw_rd", rd_a, 1'b0);
    observe(1'b0, 4, 5, 20);
    check("tw_done_at", done_at, 6);
    check("tw_wr_lo", wr_lo, 0);
    check("tw_indata", in_data_a, 8'h07);
    check("tw_parity", par_a, 1'b0);
    check("tw_sign", sign_a, 1'b0);

    // Timeout on instance b.
    address = 16'h00BE; bus_data_in = 8'h11; wait_b = 1'b0;
    pulse_start(1'b1, 1'b1, 1'b0);
    observe(1'b1, 1, 0, 30);
    check("to_done_at", done_at, 7);
    check("to_rd_lo", rd_lo, 5);
    check("to_indata", in_data_b, 8'hFF);
    check("to_flag", to_b, 1'b1);
    check("to_sign", sign_b, 1'b1);
    check("to_parity", par_b, 1'b1);

    // Next start clears TimedOut.
    bus_data_in = 8'h20; wait_b = 1'b1;
    pulse_start(1'b1, 1'b1, 1'b0);
    check("to_clear", to_b, 1'b0);
    observe(1'b1, 1, 0, 20);
    check("to2_done_at", done_at, 4);
    check("to2_flag", to_b, 1'b0);
    check("to2_indata", in_data_b, 8'h20);

    // Reset while in TW.
    wait_b = 1'b0;
    pulse_start(1'b1, 1'b1, 1'b0);
    tick();
    tick();
    check("rst_tw_state", st_b, TW);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_tw_iorq", iorq_b, 1'b1);
    check("rst_tw_rd", rd_b, 1'b1);
    check("rst_tw_busy", busy_b, 1'b0);
    check("rst_tw_done", done_b, 1'b0);
    check("rst_tw_indata", in_data_b, 8'h00);
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done_b) done_cnt++;
    end
    check("rst_tw_no_done", done_cnt, 0);
    check("rst_tw_idle", st_b, IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
